// File: rtl/bcd_pkg.sv
// Purpose: shared widths, field offsets, FSM encoding and range check for the BCD-to-binary converter.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package bcd_pkg;

  // Result width; also the number of shift-and-correct iterations.
  localparam int BIN_W = 8;
  // Hundreds digit is 2 bits (0..3 representable, 0..2 meaningful).
  localparam int HUN_W = 2;
  // Tens and ones digits are ordinary 4-bit BCD.
  localparam int DIG_W = 4;
  // Shift register holds {hun, ten, one, binary accumulator}.
  localparam int SR_W  = HUN_W + 2 * DIG_W + BIN_W;

  // Each BCD field keeps its load position for the whole conversion; bits
  // stream rightwards through it and the binary result collects at the bottom.
  localparam int ONE_LSB = BIN_W;
  localparam int TEN_LSB = BIN_W + DIG_W;
  localparam int HUN_LSB = BIN_W + 2 * DIG_W;

  // Iteration counter must reach BIN_W-1.
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True when the digits are not valid BCD or the value exceeds 255.
  function automatic logic range_err(
    input logic [HUN_W-1:0] h,
    input logic [DIG_W-1:0] t,
    input logic [DIG_W-1:0] o
  );
    logic bad_dig;
    logic too_big;
    bad_dig = (t > 4'd9) || (o > 4'd9) || (h == 2'd3);
    too_big = (h == 2'd2) && ((t > 4'd5) || ((t == 4'd5) && (o > 4'd5)));
    return bad_dig || too_big;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Purpose: one BCD digit correction step of reverse double-dabble (if >=8 then -3).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input digit.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] dig_i,
  output logic [DIG_W-1:0] dig_o
);

  // A digit that received a carried-in half-ten (8) really represents 5 in
  // this position, so pull it back by 3 to keep the field decimal.
  always_comb begin
    dig_o = dig_i;
    if (dig_i >= 4'd8) begin
      dig_o = dig_i - 4'd3;
    end
  end

endmodule

// File: rtl/bcd2bin.sv
// Purpose: iterative BCD (hun/ten/one) to 8-bit binary converter, optional range check under RANGE_CHECK_EN.
// Latency: start sampled at edge T, done pulses in the cycle after edge T+8 with bin/err valid.
// Backpressure: start ignored while busy; a new request may be presented in the done cycle.
module bcd2bin #(
  parameter int BIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       hun,
  input  logic [3:0]       ten,
  input  logic [3:0]       one,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  import bcd_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              done_q, done_d;

  logic [SR_W-1:0]   sr_shift;
  logic [SR_W-1:0]   sr_corr;
  logic [DIG_W-1:0]  ten_corr;
  logic [DIG_W-1:0]  one_corr;
  logic [BIN_W-1:0]  res_bin;
  logic              load;
  logic              finish;

  // Digits are captured only on acceptance; later input changes are ignored.
  assign load   = (state_q == ST_IDLE) && start;
  assign finish = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // One iteration: shift everything right by one, then correct the two
  // 4-bit fields. The hundreds field is too narrow to ever reach 8.
  assign sr_shift = sr_q >> 1;

  bcd_digit_corr u_ten_corr (
    .dig_i (sr_shift[TEN_LSB +: DIG_W]),
    .dig_o (ten_corr)
  );

  bcd_digit_corr u_one_corr (
    .dig_i (sr_shift[ONE_LSB +: DIG_W]),
    .dig_o (one_corr)
  );

  // Reassemble the shifted register with corrected tens and ones fields.
  always_comb begin
    sr_corr = sr_shift;
    sr_corr[TEN_LSB +: DIG_W] = ten_corr;
    sr_corr[ONE_LSB +: DIG_W] = one_corr;
  end

`ifdef RANGE_CHECK_EN
  logic chk_q, chk_d;
  logic err_q, err_d;

  // Out-of-range inputs saturate the result so a bad setpoint never wraps.
  assign res_bin = chk_q ? {BIN_W{1'b1}} : sr_corr[BIN_W-1:0];

  // Range flag is evaluated on the loaded digits and published with done.
  always_comb begin
    chk_d = chk_q;
    err_d = err_q;
    if (load) begin
      chk_d = range_err(hun, ten, one);
    end
    if (finish) begin
      err_d = chk_q;
    end
  end

  // Range-check state; cleared with the rest of the block on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Raw conversion; values above 255 wrap naturally modulo 256.
  assign res_bin = sr_corr[BIN_W-1:0];
  assign err     = 1'b0;
`endif

  // FSM next state: load on accepted start, iterate BIN_W times, then publish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bin_d   = bin_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d    = {hun, ten, one, {BIN_W{1'b0}}};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = sr_corr;
        cnt_d = cnt_q + CNT_W'(1);
        if (finish) begin
          bin_d   = res_bin;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, datapath and output registers; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bin_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign bin  = bin_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Purpose: scoreboard bench for bcd2bin; driver pushes expected results, monitor checks each done pulse.
// Latency: expects done exactly 8 cycles after the accepting edge.
// Backpressure: driver only issues when the converter is idle or in its done cycle.
module tb_bcd2bin;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] hun;
  logic [3:0] ten;
  logic [3:0] one;
  logic       busy;
  logic       done;
  logic [7:0] bin;
  logic       err;

  bcd2bin #(.BIN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .hun   (hun),
    .ten   (ten),
    .one   (one),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  typedef struct {
    logic [7:0] bin;
    logic       err;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks;
  int   fails;
  int   cyc;
  int   done_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done with bin=0x%0h, expected no done (cycle %0d)", bin, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("bin", int'(bin), int'(mon_e.bin));
        chk("err", int'(err), int'(mon_e.err));
        chk("done_cycle", cyc, mon_e.due);
      end
    end
  end

  // Present digits with start for one cycle; returns at the negedge after the load edge.
  task automatic issue(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic [7:0] eb, input logic ee, output int tl);
    @(negedge clk);
    hun = h; ten = t; one = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tl = cyc;
    sb.push_back('{eb, ee, tl + 8});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion (cycle %0d)", cyc);
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int tl;
    int d0;
    rst_n = 1'b0; start = 1'b0; hun = 2'd0; ten = 4'd0; one = 4'd0;
    checks = 0; fails = 0; cyc = 0; done_seen = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin",  int'(bin),  0);
    chk("rst_err",  int'(err),  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero, exact latency
    issue(2'd0, 4'd0, 4'd0, 8'h00, 1'b0, tl);
    drain();

    // Largest in-range value, then a mid value with busy-width check
    issue(2'd2, 4'd5, 4'd5, 8'hFF, 1'b0, tl);
    drain();
    issue(2'd1, 4'd2, 4'd8, 8'h80, 1'b0, tl);
    for (int i = 0; i < 8; i++) begin
      chk("busy_high", int'(busy), 1);
      @(negedge clk);
    end
    chk("busy_low_at_done", int'(busy), 0);
    drain();

    issue(2'd0, 4'd9, 4'd9, 8'h63, 1'b0, tl);
    drain();
    issue(2'd2, 4'd0, 4'd0, 8'hC8, 1'b0, tl);
    drain();

    // Start while busy is ignored; start held through the done cycle reloads at T+9
    d0 = done_seen;
    issue(2'd0, 4'd4, 4'd2, 8'h2A, 1'b0, tl);
    repeat (2) @(negedge clk);
    hun = 2'd1; ten = 4'd9; one = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    hun = 2'd1; ten = 4'd0; one = 4'd0; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    sb.push_back('{8'h64, 1'b0, cyc + 8});
    drain();
    chk("done_pulse_count", done_seen - d0, 2);

    // Reset in the middle of a conversion
    issue(2'd1, 4'd5, 4'd0, 8'h96, 1'b0, tl);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin",  int'(bin),  0);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);

`ifdef RANGE_CHECK_EN
    issue(2'd2, 4'd5, 4'd6, 8'hFF, 1'b1, tl);
    drain();
    issue(2'd0, 4'd4, 4'd10, 8'hFF, 1'b1, tl);
    drain();
    issue(2'd0, 4'd4, 4'd2, 8'h2A, 1'b0, tl);
    drain();
    issue(2'd3, 4'd0, 4'd0, 8'hFF, 1'b1, tl);
    drain();
`else
    issue(2'd2, 4'd5, 4'd6, 8'h00, 1'b0, tl);
    drain();
    issue(2'd3, 4'd9, 4'd9, 8'h8F, 1'b0, tl);
    drain();
    issue(2'd0, 4'd4, 4'd2, 8'h2A, 1'b0, tl);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
